// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path (and a future receiver).
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } uart_par_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int DATA_BITS_MIN = 5;

  // Keeps only the low (data_bits_field + DATA_BITS_MIN) bits of a byte.
  function automatic logic [7:0] data_mask(input logic [1:0] db);
    return 8'hFF >> (2'd3 - db);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push refused when full, pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               wdata_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               rdata_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level;
  logic             do_push, do_pop;

  assign full_o  = (level == LW'(DEPTH));
  assign empty_o = (level == '0);
  assign level_o = level;
  assign rdata_o = mem[rd_ptr];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed, run-time 5..8 data bits, none/even/odd parity, 1 or 2 stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [DIV_W-1:0]                    div_i,
  input  logic [1:0]                          data_bits_i,
  input  logic [1:0]                          parity_i,
  input  logic                                stop2_i,
  input  logic                                tx_en_i,
  input  logic [7:0]                          data_i,
  input  logic                                valid_i,
  output logic                                ready_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     level_o,
  output logic                                busy_o,
  output logic                                tx_o
);

  localparam int TICK_W = $clog2(OVERSAMPLE);

  uart_tx_state_t    state;
  logic [DIV_W-1:0]  div_r, div_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        bit_cnt, last_bit_r;
  logic              stop_cnt, stop2_r, par_en_r, par_bit_r;
  logic [7:0]        shreg, head;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic              tick, bit_end, frame_done;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (valid_i),
    .wdata_i (data_i),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  assign ready_o    = !fifo_full;
  assign tick       = (div_cnt == div_r);
  assign bit_end    = tick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));
  assign frame_done = (state == STOP) && bit_end && (stop_cnt == stop2_r);
  // A pop always coincides with a frame start, from IDLE or straight out of the last stop bit.
  assign fifo_pop   = tx_en_i && !fifo_empty && ((state == IDLE) || frame_done);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      div_cnt  <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else if (state == IDLE) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
      if (fifo_pop) state <= START;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) tick_cnt <= bit_end ? '0 : tick_cnt + TICK_W'(1);
      if (bit_end) begin
        case (state)
          START: begin
            state   <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            if (bit_cnt == last_bit_r) begin
              state    <= par_en_r ? PARITY : STOP;
              stop_cnt <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          PARITY: begin
            state    <= STOP;
            stop_cnt <= 1'b0;
          end
          STOP: begin
            if (stop_cnt == stop2_r) state <= fifo_pop ? START : IDLE;
            else                     stop_cnt <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Frame configuration is captured at pop so mid-frame input changes cannot disturb the line.
  always_ff @(posedge clk_i) begin
    if (fifo_pop) begin
      shreg      <= head;
      div_r      <= div_i;
      last_bit_r <= 3'(DATA_BITS_MIN - 1) + {1'b0, data_bits_i};
      par_en_r   <= (parity_i == PAR_EVEN) || (parity_i == PAR_ODD);
      par_bit_r  <= (^(head & data_mask(data_bits_i))) ^ (parity_i == PAR_ODD);
      stop2_r    <= stop2_i;
    end else if ((state == DATA) && bit_end) begin
      shreg <= shreg >> 1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_o   <= 1'b1;
      busy_o <= 1'b0;
    end else begin
      busy_o <= (state != IDLE);
      case (state)
        START:   tx_o <= 1'b0;
        DATA:    tx_o <= shreg[0];
        PARITY:  tx_o <= par_bit_r;
        default: tx_o <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame shape, parity, FIFO fill/drain, config latching, tx_en and reset.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] div;
  logic [1:0]  dbits, par;
  logic        stop2, tx_en, valid;
  logic [7:0]  data;
  logic        ready, busy, tx;
  logic [4:0]  level;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .OVERSAMPLE (16),
    .DIV_W      (16),
    .FIFO_DEPTH (16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .div_i       (div),
    .data_bits_i (dbits),
    .parity_i    (par),
    .stop2_i     (stop2),
    .tx_en_i     (tx_en),
    .data_i      (data),
    .valid_i     (valid),
    .ready_o     (ready),
    .level_o     (level),
    .busy_o      (busy),
    .tx_o        (tx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int cyc);
    repeat (cyc) @(negedge clk);
  endtask

  // Called at a negedge; the push lands on the following posedge.
  task automatic push(input logic [7:0] b);
    data  = b;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_fall(input string tag, output int cnt);
    cnt = 0;
    while (tx !== 1'b0 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, " start fall"}, 32'(tx), 32'd0);
  endtask

  // Entered at the first low sample of the start bit; returns at the last cycle of the last stop bit.
  task automatic expect_frame(input string tag, input logic [7:0] d, input int nbits,
                              input int pbit, input int nstop, input int bitlen);
    int   total, off, tgt;
    logic eb;
    total = 1 + nbits + ((pbit >= 0) ? 1 : 0) + nstop;
    off   = 0;
    for (int i = 0; i < total; i++) begin
      if (i == 0)                             eb = 1'b0;
      else if (i <= nbits)                    eb = d[i-1];
      else if (pbit >= 0 && i == nbits + 1)   eb = pbit[0];
      else                                    eb = 1'b1;
      tgt = i * bitlen;
      adv(tgt - off);
      off = tgt;
      check($sformatf("%s bit%0d first", tag, i), 32'(tx), 32'(eb));
      tgt = i * bitlen + bitlen - 1;
      adv(tgt - off);
      off = tgt;
      check($sformatf("%s bit%0d last", tag, i), 32'(tx), 32'(eb));
    end
    check({tag, " busy at end"}, 32'(busy), 32'd1);
  endtask

  function automatic logic [7:0] fill_val(input int i);
    return 8'(i * 37 + 11);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; div = '0; dbits = 2'd3; par = 2'd0; stop2 = 1'b0;
    tx_en = 1'b1; data = '0; valid = 1'b0;
    adv(2);
    check("rst tx", 32'(tx), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst ready", 32'(ready), 32'd1);
    check("rst level", 32'(level), 32'd0);
    rst_n = 1'b1;
    adv(1);

    // 8N1, div 0, 0x55
    push(8'h55);
    check("8n1 level after push", 32'(level), 32'd1);
    wait_fall("8n1", n);
    check("8n1 latency", 32'(n), 32'd2);
    expect_frame("8n1", 8'h55, 8, -1, 1, 16);
    adv(1);
    check("8n1 busy at 160", 32'(busy), 32'd0);
    check("8n1 idle line", 32'(tx), 32'd1);
    check("8n1 level drained", 32'(level), 32'd0);

    // 7E2, div 3, 0x83
    div = 16'd3; dbits = 2'd2; par = 2'd1; stop2 = 1'b1;
    push(8'h83);
    wait_fall("7e2", n);
    check("7e2 latency", 32'(n), 32'd2);
    expect_frame("7e2", 8'h83, 7, 0, 2, 64);
    adv(1);
    check("7e2 busy at 704", 32'(busy), 32'd0);

    // 5O1 back-to-back, div 0
    div = 16'd0; dbits = 2'd0; par = 2'd2; stop2 = 1'b0;
    push(8'h1F);
    push(8'h1E);
    wait_fall("5o1", n);
    expect_frame("5o1 1F", 8'h1F, 5, 0, 1, 16);
    adv(1);
    expect_frame("5o1 1E", 8'h1E, 5, 1, 1, 16);
    adv(1);
    check("5o1 busy end", 32'(busy), 32'd0);

    // Fill FIFO with transmitter disabled, then drain back-to-back
    dbits = 2'd3; par = 2'd0; tx_en = 1'b0;
    for (int i = 0; i < 16; i++) push(fill_val(i));
    check("fill level", 32'(level), 32'd16);
    check("fill ready", 32'(ready), 32'd0);
    push(8'hEE);
    check("fill 17th refused", 32'(level), 32'd16);
    check("fill busy", 32'(busy), 32'd0);
    check("fill line idle", 32'(tx), 32'd1);
    tx_en = 1'b1;
    wait_fall("drain", n);
    check("drain latency", 32'(n), 32'd2);
    check("drain level after pop", 32'(level), 32'd15);
    for (int i = 0; i < 16; i++) begin
      expect_frame($sformatf("drain%0d", i), fill_val(i), 8, -1, 1, 16);
      adv(1);
    end
    check("drain busy end", 32'(busy), 32'd0);
    check("drain level end", 32'(level), 32'd0);

    // Config change mid-DATA affects only the next frame
    push(8'h3C);
    push(8'h97);
    wait_fall("cfg", n);
    fork
      begin
        adv(40);
        div = 16'd1; par = 2'd1; stop2 = 1'b1;
      end
    join_none
    expect_frame("cfg old", 8'h3C, 8, -1, 1, 16);
    adv(1);
    expect_frame("cfg new", 8'h97, 8, 1, 2, 32);
    adv(1);
    check("cfg busy end", 32'(busy), 32'd0);

    // tx_en dropped mid-DATA with two entries queued
    div = 16'd0; par = 2'd0; stop2 = 1'b0;
    push(8'h5A);
    wait_fall("txen", n);
    fork
      begin
        push(8'hD1);
        push(8'hE2);
        adv(30);
        tx_en = 1'b0;
      end
    join_none
    expect_frame("txen", 8'h5A, 8, -1, 1, 16);
    adv(1);
    check("txen busy", 32'(busy), 32'd0);
    check("txen line", 32'(tx), 32'd1);
    check("txen level", 32'(level), 32'd2);
    adv(50);
    check("txen line later", 32'(tx), 32'd1);
    check("txen level later", 32'(level), 32'd2);

    // Reset asserted during the parity bit
    par = 2'd1; tx_en = 1'b1;
    wait_fall("rstmid", n);
    check("rstmid latency", 32'(n), 32'd2);
    check("rstmid level", 32'(level), 32'd1);
    adv(150);
    check("rstmid in parity", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid async tx", 32'(tx), 32'd1);
    check("rstmid async busy", 32'(busy), 32'd0);
    check("rstmid async level", 32'(level), 32'd0);
    check("rstmid async ready", 32'(ready), 32'd1);
    adv(2);
    rst_n = 1'b1;
    adv(3);
    check("post rst line", 32'(tx), 32'd1);
    check("post rst busy", 32'(busy), 32'd0);
    push(8'hA5);
    wait_fall("post rst", n);
    check("post rst latency", 32'(n), 32'd2);
    expect_frame("post rst", 8'hA5, 8, 0, 1, 16);
    adv(1);
    check("post rst busy end", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered 8N1-superset UART transmitter for the MMIO trace path. It accepts bytes over a valid/ready handshake into an internal FIFO and serialises them LSB first. Frame format is selectable at run time: 5–8 data bits, none/even/odd parity, and 1 or 2 stop bits. It replaces the fixed 8N1 single-byte transmitter wherever trace output must not stall the core on every byte.

## Interface
- `OVERSAMPLE`, 16: baud ticks per bit; ≥4.
- `DIV_W`, 16: width of the divider input.
- `FIFO_DEPTH`, 16: entries; a power of two, ≥2.
- `clk_i  in  1`: clock.
- `rst_ni  in  1`: asynchronous active-low reset.
- `div_i  in  DIV_W`: baud tick every `div_i`+1 clocks; bit period = `OVERSAMPLE`·(`div_i`+1) clocks.
- `data_bits_i  in  2`: data bit count minus 5 (0→5 … 3→8).
- `parity_i  in  2`: `PAR_NONE`=0, `PAR_EVEN`=1, `PAR_ODD`=2; 3 is treated as none.
- `stop2_i  in  1`: 1 selects two stop bits.
- `tx_en_i  in  1`: when 0, no new frame starts; a frame in progress completes.
- `data_i  in  8`: write data; bits above the data bit count are ignored.
- `valid_i  in  1`: write request.
- `ready_o  out  1`: FIFO not full.
- `level_o  out  $clog2(FIFO_DEPTH+1)`: current FIFO occupancy.
- `busy_o  out  1`: a frame is on the line.
- `tx_o  out  1`: serial output, idle high.

## Operation
- Push on the rising edge where `valid_i`&&`ready_o`. The push is refused when full, even if a pop happens in the same cycle.
- FSM states: `IDLE`, `START`, `DATA`, `PARITY`, `STOP`.
- **IDLE:** if `tx_en_i` and the FIFO is non-empty:
  - pop the head;
  - latch data, `div_i`, `data_bits_i`, `parity_i`, `stop2_i` into the frame registers (mid-frame input changes have no effect);
  - clear the divider and tick counters; go to `START`.
- **START:** 1 bit period, then `DATA`.
- **DATA:** `data_bits` bit periods, LSB first.
  - Then `PARITY` if parity is enabled, else `STOP`.
- **PARITY:** 1 bit period.
  - Even: bit = XOR of the sent data bits.
  - Odd: its inverse.
  - Then `STOP`.
- **STOP:** 1 or 2 bit periods, line high.
  - At the final tick, if `tx_en_i` and the FIFO is non-empty: pop and go straight to `START`, with no idle gap.
  - Otherwise go to `IDLE`.
- Baud divider runs only outside `IDLE` and restarts at each frame start, so the start bit has exact length.
- `busy_o` = state≠`IDLE`.

## Timing
- Reset values: `tx_o`=1, `busy_o`=0, `ready_o`=1, `level_o`=0, FSM in `IDLE`, FIFO empty.
- `tx_o` is registered. With an empty FIFO, push accepted at edge N → pop at edge N+1 → `tx_o` low from edge N+2.
- Frame length = (1 + D + P + S)·`OVERSAMPLE`·(`div_i`+1) clocks, where D = data bits, P = 1 if parity is enabled else 0, S = stop bits.
- Back-to-back frames: the next start bit begins on the clock after the last stop-bit period ends.
- `level_o` and `ready_o` update on the edge after a push or pop.
  - A simultaneous push and pop leaves the level unchanged.
- `tx_en_i` deasserted mid-frame: the current frame finishes, then the FSM idles; the FIFO retains its contents.
- Reset asserted mid-frame: outputs return to reset values immediately, the FIFO empties, and the line goes high with no partial-frame recovery.
- `div_i`=0 is legal: one tick per clock.

## Structure
- Package `uart_pkg` holds:
  - `uart_par_t` (`PAR_NONE`/`PAR_EVEN`/`PAR_ODD`);
  - `uart_tx_state_t`;
  - the `DATA_BITS_MIN`=5 constant.
- Sub-module `sync_fifo`, parameters WIDTH=8 and DEPTH. It has push/pop/full/empty/level and an async active-low reset, and is reusable by a future receiver.
- Divider, tick counter, bit counter and shift register live in the top level.

## Test plan
- `div_i`=0, OVERSAMPLE=16, 8N1, push 0x55:
  - `tx_o` falls 2 clocks after the push;
  - bits 1,0,1,0,1,0,1,0 follow, each held 16 clocks;
  - stop high for 16 clocks;
  - `busy_o` falls at 160 clocks.
- `div_i`=3, 7 bits, even parity, 2 stop, push 0x83:
  - data bits 1,1,0,0,0,0,0 (bit 7 dropped), parity 0, two stop bits;
  - each bit lasts 64 clocks; frame length 704 clocks.
- Odd parity, 5 bits, push 0x1F → parity bit 0; push 0x1E → parity bit 1.
- Push 17 bytes with `tx_en_i`=0 at FIFO_DEPTH=16:
  - `ready_o` falls after 16 pushes and `level_o`=16; the 17th byte is not accepted.
  - Raise `tx_en_i`: 16 frames go out back-to-back with no idle gap, in FIFO order.
- Mid-DATA changes:
  - toggle `div_i`, `parity_i`, `stop2_i` mid-DATA → current frame unchanged, next frame uses the new config;
  - drop `tx_en_i` mid-DATA with the FIFO holding 2 entries → frame completes, `level_o` stays 2, `tx_o` stays 1.
- Assert `rst_ni` mid-PARITY:
  - `tx_o`=1, `busy_o`=0, `level_o`=0, `ready_o`=1 asynchronously;
  - after release, a new push transmits a clean frame.
